// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// Imported by the top level and the winner-selection block.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    XFER = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_id_t;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b10;

  // Width of the wait and starve counters; both parameters are limited to 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch and data requesters,
// plus the next value of the fetch-starvation counter.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic             i_arb_en,
  input  logic             i_if_req,
  input  logic             i_d_req,
  input  logic [CNT_W-1:0] i_starve_cnt,
  output logic             o_pick_if,
  output logic             o_pick_d,
  output logic [CNT_W-1:0] o_starve_nxt
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic w_force_if;
  logic w_pick_if;
  logic w_pick_d;

  assign w_force_if = (i_starve_cnt == LIMIT);
  // Data wins by default; fetch wins when alone or once it has waited long enough.
  assign w_pick_if  = i_arb_en && i_if_req && (!i_d_req || w_force_if);
  assign w_pick_d   = i_arb_en && i_d_req && !w_pick_if;

  assign o_pick_if = w_pick_if;
  assign o_pick_d  = w_pick_d;

  always_comb begin
    o_starve_nxt = i_starve_cnt;
    if (i_arb_en) begin
      if (w_pick_if || !i_if_req) begin
        o_starve_nxt = '0;
      end else if (w_pick_d && (i_starve_cnt != LIMIT)) begin
        o_starve_nxt = i_starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one byte-addressed data memory between the fetch and load/store ports:
// one access at a time, optional wait states, registered one-cycle responses.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WAIT_CYCLES  = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_length,
  input  logic        d_sign,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  output logic [1:0]  mem_length,
  output logic        mem_sign,
  input  logic [31:0] mem_data_out,
  output logic        busy
);

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);

  arb_state_t       r_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] r_starve;
  port_id_t         r_port;
  logic [31:0]      r_addr;
  logic             r_wr;
  logic [31:0]      r_wdata;
  logic [1:0]       r_length;
  logic             r_sign;
  logic             r_if_rvalid;
  logic             r_d_rvalid;
  logic [31:0]      r_if_rdata;
  logic [31:0]      r_d_rdata;

  logic             w_arb_en;
  logic             w_pick_if;
  logic             w_pick_d;
  logic [CNT_W-1:0] w_starve_nxt;
  logic             w_xfer;

  // Handshake: a requester holds req with its command stable until the
  // combinational gnt pulse; the command is captured on that cycle's posedge
  // and the single-cycle rvalid follows WAIT_CYCLES + 2 cycles after gnt.
  assign w_arb_en = (r_state == IDLE) && !rst;

  mem_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .i_arb_en    (w_arb_en),
    .i_if_req    (if_req),
    .i_d_req     (d_req),
    .i_starve_cnt(r_starve),
    .o_pick_if   (w_pick_if),
    .o_pick_d    (w_pick_d),
    .o_starve_nxt(w_starve_nxt)
  );

  // rst gates the strobe directly so a store caught mid-access is never written.
  assign w_xfer      = (r_state == XFER) && !rst;
  assign mem_enable  = w_xfer;
  assign mem_wr      = w_xfer && r_wr;
  assign mem_addr    = r_addr;
  assign mem_data_in = r_wdata;
  assign mem_length  = r_length;
  assign mem_sign    = r_sign;

  assign if_gnt    = w_pick_if;
  assign d_gnt     = w_pick_d;
  assign if_rvalid = r_if_rvalid;
  assign if_rdata  = r_if_rdata;
  assign d_rvalid  = r_d_rvalid;
  assign d_rdata   = r_d_rdata;
  assign busy      = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_wait_cnt  <= '0;
      r_starve    <= '0;
      r_port      <= PORT_IF;
      r_addr      <= '0;
      r_wr        <= 1'b0;
      r_wdata     <= '0;
      r_length    <= '0;
      r_sign      <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_starve    <= w_starve_nxt;
      case (r_state)
        IDLE: begin
          r_wait_cnt <= '0;
          if (w_pick_if) begin
            r_port   <= PORT_IF;
            r_addr   <= if_addr;
            r_wr     <= 1'b0;
            r_wdata  <= '0;
            r_length <= LEN_WORD;
            r_sign   <= 1'b0;
            r_state  <= (WAIT_CYCLES > 0) ? WAIT : XFER;
          end else if (w_pick_d) begin
            r_port   <= PORT_D;
            r_addr   <= d_addr;
            r_wr     <= d_wr;
            r_wdata  <= d_wdata;
            r_length <= d_length;
            r_sign   <= d_sign;
            r_state  <= (WAIT_CYCLES > 0) ? WAIT : XFER;
          end
        end
        WAIT: begin
          if (r_wait_cnt == WAIT_LAST) begin
            r_state <= XFER;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        XFER: begin
          r_state <= IDLE;
          if (r_port == PORT_IF) begin
            r_if_rvalid <= 1'b1;
            r_if_rdata  <= mem_data_out;
          end else begin
            r_d_rvalid <= 1'b1;
            r_d_rdata  <= r_wr ? 32'h0 : mem_data_out;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (0 and 3 wait states) with a byte
// memory model each, a transaction-level reference model and a scoreboard.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  int unsigned cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        if_req [2];
  logic [31:0] if_addr [2];
  logic        if_gnt [2];
  logic        if_rvalid [2];
  logic [31:0] if_rdata [2];
  logic        d_req [2];
  logic        d_wr [2];
  logic [31:0] d_addr [2];
  logic [31:0] d_wdata [2];
  logic [1:0]  d_length [2];
  logic        d_sign [2];
  logic        d_gnt [2];
  logic        d_rvalid [2];
  logic [31:0] d_rdata [2];
  logic        mem_enable [2];
  logic        mem_wr [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_data_in [2];
  logic [1:0]  mem_length [2];
  logic        mem_sign [2];
  logic [31:0] mem_data_out [2];
  logic        busy [2];

  typedef struct packed {
    int unsigned rv_cyc;
    logic        is_if;
    logic        wr;
    logic [1:0]  len;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } rec_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int WG = (g == 0) ? 0 : 3;
    localparam int SG = (g == 0) ? 2 : 4;

    logic [7:0]  env_mem [1024];
    logic [7:0]  ref_mem [1024];
    rec_t        exp_q [$];
    int          starve = 0;
    logic [31:0] last_if = 0;
    logic [31:0] last_d = 0;

    mem_port_arbiter #(
      .WAIT_CYCLES (WG),
      .STARVE_LIMIT(SG)
    ) dut (
      .clk         (clk),
      .rst         (rst),
      .if_req      (if_req[g]),
      .if_addr     (if_addr[g]),
      .if_gnt      (if_gnt[g]),
      .if_rvalid   (if_rvalid[g]),
      .if_rdata    (if_rdata[g]),
      .d_req       (d_req[g]),
      .d_wr        (d_wr[g]),
      .d_addr      (d_addr[g]),
      .d_wdata     (d_wdata[g]),
      .d_length    (d_length[g]),
      .d_sign      (d_sign[g]),
      .d_gnt       (d_gnt[g]),
      .d_rvalid    (d_rvalid[g]),
      .d_rdata     (d_rdata[g]),
      .mem_enable  (mem_enable[g]),
      .mem_wr      (mem_wr[g]),
      .mem_addr    (mem_addr[g]),
      .mem_data_in (mem_data_in[g]),
      .mem_length  (mem_length[g]),
      .mem_sign    (mem_sign[g]),
      .mem_data_out(mem_data_out[g]),
      .busy        (busy[g])
    );

    // Little-endian byte memory read; length 11 reads as zero.
    function automatic logic [31:0] mrd(input bit from_ref, input logic [31:0] a,
                                        input logic [1:0] len, input logic sgn);
      logic [9:0] i;
      logic [7:0] b0, b1, b2, b3;
      i  = a[9:0];
      b0 = from_ref ? ref_mem[i]       : env_mem[i];
      b1 = from_ref ? ref_mem[i+10'd1] : env_mem[i+10'd1];
      b2 = from_ref ? ref_mem[i+10'd2] : env_mem[i+10'd2];
      b3 = from_ref ? ref_mem[i+10'd3] : env_mem[i+10'd3];
      case (len)
        2'b00:   return sgn ? {{24{b0[7]}}, b0} : {24'h0, b0};
        2'b01:   return sgn ? {{16{b1[7]}}, b1, b0} : {16'h0, b1, b0};
        2'b10:   return {b3, b2, b1, b0};
        default: return 32'h0;
      endcase
    endfunction

    function automatic void mwr(input bit to_ref, input logic [31:0] a,
                                input logic [31:0] d, input logic [1:0] len);
      logic [9:0] i;
      int nb;
      i  = a[9:0];
      nb = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : (len == 2'b10) ? 4 : 0;
      for (int k = 0; k < nb; k++) begin
        if (to_ref) ref_mem[i+10'(k)] = d[8*k +: 8];
        else        env_mem[i+10'(k)] = d[8*k +: 8];
      end
    endfunction

    initial begin
      for (int i = 0; i < 1024; i++) begin
        env_mem[i] = 8'h0;
        ref_mem[i] = 8'h0;
      end
      mem_data_out[g] = 32'h0;
    end

    // Memory instance stand-in: writes at the falling edge, read data settles before the next posedge.
    always @(negedge clk) begin : env
      if (mem_enable[g] && mem_wr[g]) mwr(1'b0, mem_addr[g], mem_data_in[g], mem_length[g]);
      mem_data_out[g] <= mrd(1'b0, mem_addr[g], mem_length[g], mem_sign[g]);
    end

    always @(negedge clk) begin : mon
      rec_t h;
      bit has, idle, exp_en, exp_rv, exp_busy, exp_if, exp_d;
      if (rst) begin
        check("mem_enable_in_rst", 32'(mem_enable[g]), 32'h0);
        exp_q.delete();
        starve  = 0;
        last_if = 0;
        last_d  = 0;
      end else begin
        has      = exp_q.size() != 0;
        h        = has ? exp_q[0] : '0;
        exp_en   = has && (cyc == h.rv_cyc - 1);
        exp_rv   = has && (cyc == h.rv_cyc);
        exp_busy = has && (cyc + WG + 2 > h.rv_cyc) && (cyc < h.rv_cyc);
        check("mem_enable", 32'(mem_enable[g]), 32'(exp_en));
        check("mem_wr", 32'(mem_wr[g]), 32'(exp_en && h.wr));
        check("busy", 32'(busy[g]), 32'(exp_busy));
        check("if_rvalid", 32'(if_rvalid[g]), 32'(exp_rv && h.is_if));
        check("d_rvalid", 32'(d_rvalid[g]), 32'(exp_rv && !h.is_if));
        if (exp_en) begin
          check("mem_addr", mem_addr[g], h.addr);
          check("mem_length", 32'(mem_length[g]), 32'(h.len));
          check("mem_sign", 32'(mem_sign[g]), 32'(h.sgn));
          if (h.wr) check("mem_data_in", mem_data_in[g], h.wdata);
        end
        if (exp_rv) begin
          if (h.is_if) last_if = h.exp;
          else         last_d  = h.exp;
          if (h.wr) mwr(1'b1, h.addr, h.wdata, h.len);
          void'(exp_q.pop_front());
        end
        check("if_rdata", if_rdata[g], last_if);
        check("d_rdata", d_rdata[g], last_d);
        idle   = exp_q.size() == 0;
        exp_if = idle && if_req[g] && (!d_req[g] || starve == SG);
        exp_d  = idle && d_req[g] && !exp_if;
        check("if_gnt", 32'(if_gnt[g]), 32'(exp_if));
        check("d_gnt", 32'(d_gnt[g]), 32'(exp_d));
        if (idle) begin
          if (exp_if || !if_req[g]) starve = 0;
          else if (exp_d && starve < SG) starve++;
        end
        if (exp_if) begin
          exp_q.push_back('{cyc + WG + 2, 1'b1, 1'b0, 2'b10, 1'b0, if_addr[g], 32'h0,
                            mrd(1'b1, if_addr[g], 2'b10, 1'b0)});
        end else if (exp_d) begin
          exp_q.push_back('{cyc + WG + 2, 1'b0, d_wr[g], d_length[g], d_sign[g], d_addr[g],
                            d_wdata[g],
                            d_wr[g] ? 32'h0 : mrd(1'b1, d_addr[g], d_length[g], d_sign[g])});
        end
      end
    end
  end

  task automatic txn(input int p, input bit is_if, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [1:0] len, input logic sgn,
                     output logic [31:0] rdata, output int lat);
    int n;
    int unsigned gc;
    rdata = 32'h0;
    lat   = 0;
    if (is_if) begin
      if_addr[p] = addr;
      if_req[p]  = 1'b1;
    end else begin
      d_wr[p]     = wr;
      d_addr[p]   = addr;
      d_wdata[p]  = wdata;
      d_length[p] = len;
      d_sign[p]   = sgn;
      d_req[p]    = 1'b1;
    end
    n = 0;
    @(negedge clk);
    while (!(is_if ? if_gnt[p] : d_gnt[p]) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      check("gnt_timeout", 32'h1, 32'h0);
      if_req[p] = 1'b0;
      d_req[p]  = 1'b0;
      return;
    end
    gc = cyc;
    @(posedge clk);
    #1;
    if_req[p] = 1'b0;
    d_req[p]  = 1'b0;
    n = 0;
    @(negedge clk);
    while (!(is_if ? if_rvalid[p] : d_rvalid[p]) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      check("rvalid_timeout", 32'h1, 32'h0);
      return;
    end
    rdata = is_if ? if_rdata[p] : d_rdata[p];
    lat   = int'(cyc - gc);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input int p);
    check("q_if_gnt", 32'(if_gnt[p]), 0);
    check("q_if_rvalid", 32'(if_rvalid[p]), 0);
    check("q_if_rdata", if_rdata[p], 0);
    check("q_d_gnt", 32'(d_gnt[p]), 0);
    check("q_d_rvalid", 32'(d_rvalid[p]), 0);
    check("q_d_rdata", d_rdata[p], 0);
    check("q_mem_enable", 32'(mem_enable[p]), 0);
    check("q_mem_wr", 32'(mem_wr[p]), 0);
    check("q_mem_addr", mem_addr[p], 0);
    check("q_mem_data_in", mem_data_in[p], 0);
    check("q_mem_length", 32'(mem_length[p]), 0);
    check("q_mem_sign", 32'(mem_sign[p]), 0);
    check("q_busy", 32'(busy[p]), 0);
  endtask

  task automatic rand_run(input int p, input int ncyc);
    bit gi, gd;
    for (int c = 0; c < ncyc + 200; c++) begin
      @(negedge clk);
      gi = if_gnt[p];
      gd = d_gnt[p];
      @(posedge clk);
      #1;
      if (gi) if_req[p] = 1'b0;
      if (gd) d_req[p] = 1'b0;
      if (c < ncyc) begin
        if (!if_req[p] && $urandom_range(0, 2) == 0) begin
          if_addr[p] = $urandom_range(32'h100, 32'h13F);
          if_req[p]  = 1'b1;
        end
        if (!d_req[p] && $urandom_range(0, 2) == 0) begin
          d_wr[p]     = 1'($urandom_range(0, 1));
          d_addr[p]   = $urandom_range(32'h100, 32'h13F);
          d_wdata[p]  = $urandom;
          d_length[p] = 2'($urandom_range(0, 3));
          d_sign[p]   = 1'($urandom_range(0, 1));
          d_req[p]    = 1'b1;
        end
      end else if (!if_req[p] && !d_req[p]) begin
        break;
      end
    end
    if (if_req[p] || d_req[p]) begin
      check("rand_drain", 32'h1, 32'h0);
      if_req[p] = 1'b0;
      d_req[p]  = 1'b0;
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  logic [31:0] rd;
  int lat;
  logic [5:0] order;
  int k, n;

  initial begin
    rst = 1'b1;
    for (int p = 0; p < 2; p++) begin
      if_req[p] = 0; if_addr[p] = 0; d_req[p] = 0; d_wr[p] = 0;
      d_addr[p] = 0; d_wdata[p] = 0; d_length[p] = 0; d_sign[p] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_quiet(0);
    chk_quiet(1);

    // Zero wait states: store, readback, sub-word loads, invalid length.
    txn(0, 0, 1, 32'h100, 32'hDEADBEEF, 2'b10, 0, rd, lat);
    check("st_rdata", rd, 32'h0);
    check("st_lat", lat, 2);
    txn(0, 0, 0, 32'h100, 32'h0, 2'b10, 0, rd, lat);
    check("ld_word", rd, 32'hDEADBEEF);
    txn(0, 0, 0, 32'h100, 32'h0, 2'b00, 1, rd, lat);
    check("ld_byte_s", rd, 32'hFFFFFFEF);
    txn(0, 0, 0, 32'h100, 32'h0, 2'b01, 0, rd, lat);
    check("ld_half_u", rd, 32'h0000BEEF);
    txn(0, 0, 0, 32'h100, 32'h0, 2'b11, 0, rd, lat);
    check("ld_len11", rd, 32'h0);
    txn(0, 0, 1, 32'h100, 32'h12345678, 2'b11, 0, rd, lat);
    check("st_len11", rd, 32'h0);
    txn(0, 0, 0, 32'h100, 32'h0, 2'b10, 0, rd, lat);
    check("ld_after_len11", rd, 32'hDEADBEEF);

    // Both requesters held: limit 2 gives D, D, IF, D, D, IF.
    if_addr[0] = 32'h104; if_req[0] = 1'b1;
    d_wr[0] = 0; d_addr[0] = 32'h100; d_length[0] = 2'b10; d_sign[0] = 0; d_req[0] = 1'b1;
    order = '0; k = 0; n = 0;
    while (k < 6 && n < 100) begin
      @(negedge clk);
      if (if_gnt[0] && d_gnt[0]) check("both_gnt", 32'h1, 32'h0);
      if (if_gnt[0]) begin order[k] = 1'b1; k++; end
      else if (d_gnt[0]) k++;
      n++;
    end
    check("starve_count", k, 6);
    check("starve_order", 32'(order), 32'(6'b100100));
    @(posedge clk);
    #1 if_req[0] = 1'b0; d_req[0] = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // Reset during the access cycle of a store: must not reach memory.
    d_wr[0] = 1; d_addr[0] = 32'h300; d_wdata[0] = 32'h11223344; d_length[0] = 2'b10;
    d_req[0] = 1'b1;
    @(negedge clk);
    check("rx_gnt", 32'(d_gnt[0]), 32'h1);
    @(posedge clk);
    #1 d_req[0] = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk_quiet(0);
    txn(0, 0, 0, 32'h300, 32'h0, 2'b10, 0, rd, lat);
    check("ld_after_rst_xfer", rd, 32'h0);

    rand_run(0, 400);

    // Three wait states: store, then fetch of the same word.
    txn(1, 0, 1, 32'h100, 32'hDEADBEEF, 2'b10, 0, rd, lat);
    check("w3_st_lat", lat, 5);
    txn(1, 1, 0, 32'h100, 32'h0, 2'b10, 0, rd, lat);
    check("w3_fetch", rd, 32'hDEADBEEF);
    check("w3_fetch_lat", lat, 5);

    // Reset while a store waits: no write, no response, quiet outputs.
    d_wr[1] = 1; d_addr[1] = 32'h200; d_wdata[1] = 32'hCAFEF00D; d_length[1] = 2'b10;
    d_sign[1] = 0; d_req[1] = 1'b1;
    @(negedge clk);
    check("rw_gnt", 32'(d_gnt[1]), 32'h1);
    @(posedge clk);
    #1 d_req[1] = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    check("rw_busy", 32'(busy[1]), 32'h1);
    @(posedge clk);
    #1 rst = 1'b0;
    chk_quiet(1);
    chk_quiet(0);
    repeat (8) @(posedge clk);
    #1;
    txn(1, 0, 0, 32'h200, 32'h0, 2'b10, 0, rd, lat);
    check("ld_after_rst_wait", rd, 32'h0);

    rand_run(1, 400);

    check("drain0", lane[0].exp_q.size(), 0);
    check("drain1", lane[1].exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
